// File: rtl/mips_hazard_scoreboard.sv
// Issue interlock between decode and execute: tracks in-flight register writes, stalls RAW hazards, drains HLT.
// Build option SCOREBOARD_WB_BYPASS_EN: write-before-read register file, so the retiring slot no longer blocks readers.
module mips_hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_halt,
    input  logic              flush,
    output logic              issue,
    output logic              stall,
    output logic [NREG-1:0]   pending,
    output logic              halted,
    output logic [CW-1:0]     stall_count
);

    localparam int NIDX = 1 << REG_AW;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam int EFF_SLOTS = DEPTH - 1;
`else
    localparam int EFF_SLOTS = DEPTH;
`endif

    logic [DEPTH-1:0]  r_vld;
    logic [REG_AW-1:0] r_rd [DEPTH];
    logic              r_halt_pend;
    logic              r_halted;
    logic [CW-1:0]     r_cnt;

    logic [NIDX-1:0]   w_pend_all;
    logic [NIDX-1:0]   w_pend_eff;
    logic              w_hazard;
    logic              w_load;

    // Index space is 2^REG_AW wide so any source index can be looked up safely.
    always_comb begin
        w_pend_all = '0;
        w_pend_eff = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_vld[k]) begin
                w_pend_all[r_rd[k]] = 1'b1;
                if (k < EFF_SLOTS) begin
                    w_pend_eff[r_rd[k]] = 1'b1;
                end
            end
        end
        w_pend_all[0] = 1'b0;
        w_pend_eff[0] = 1'b0;
    end

    assign w_hazard = (id_rs_used & w_pend_eff[id_rs]) | (id_rt_used & w_pend_eff[id_rt]);
    assign issue    = id_valid & ~w_hazard & ~flush & ~r_halt_pend;
    assign stall    = id_valid &  w_hazard & ~flush & ~r_halt_pend;
    assign w_load   = issue & id_wr_en & (id_rd != '0);

    assign pending     = w_pend_all[NREG-1:0];
    assign halted      = r_halted;
    assign stall_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= w_load;
            r_rd[0]  <= id_rd;
        end
    end

    // halted only sets once the tracker is already empty going into the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt_pend <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            if (issue && id_halt) begin
                r_halt_pend <= 1'b1;
            end
            if (r_halt_pend && (r_vld == '0)) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for mips_hazard_scoreboard (DEPTH=3, CW=4); expectations follow the bypass build option.
module tb_mips_hazard_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam int RAW_STALLS = 2;
`else
    localparam int RAW_STALLS = 3;
`endif
    localparam int PERIOD = RAW_STALLS + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        issue, stall, halted;
    logic [31:0] pending;
    logic [3:0]  stall_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt;
    int st;

    mips_hazard_scoreboard #(.NREG(32), .REG_AW(5), .DEPTH(3), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_rd(id_rd), .id_halt(id_halt), .flush(flush),
        .issue(issue), .stall(stall), .pending(pending),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic wr, input logic [4:0] rd,
                       input logic h, input logic f);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
        id_wr_en = wr; id_rd = rd; id_halt = h; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_pending", pending, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", stall_count, 0);
        chk("rst_issue", issue, 1);
        chk("rst_stall", stall, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // RAW chain: producer rd=1, consumer rs=1 on the next cycle
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("raw_prod_issue", issue, 1);
        tick();
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c <= RAW_STALLS; c++) begin
            @(negedge clk);
            chk("raw_stall", stall, c < RAW_STALLS);
            chk("raw_issue", issue, c == RAW_STALLS);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("raw_count", stall_count, RAW_STALLS);
        exp_cnt = RAW_STALLS;
        idle(3);

        // Independent stream
        for (int r = 1; r <= 3; r++) begin
            drv(1, 0, 0, 0, 0, 1, 5'(r), 0, 0);
            @(negedge clk);
            chk("ind_issue", issue, 1);
            chk("ind_stall", stall, 0);
            tick();
        end
        drv(1, 4, 5, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("ind_pending_peak", pending, 32'h0000_000E);
        chk("ind_reader_issue", issue, 1);
        chk("ind_reader_stall", stall, 0);
        chk("ind_count", stall_count, exp_cnt);
        tick();
        idle(3);

        // R0 handling
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("r0_wr_issue", issue, 1);
        tick();
        drv(1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_pending", pending, 0);
        chk("r0_stall", stall, 0);
        chk("r0_issue", issue, 1);
        tick();
        idle(3);

        // Flush priority over hazard
        drv(1, 0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        drv(1, 7, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("flush_pend7", pending[7], 1);
        chk("flush_issue", issue, 0);
        chk("flush_stall", stall, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_count", stall_count, exp_cnt);
        idle(3);

        // Self-reference is not a hazard; the repeat is
        drv(1, 8, 8, 1, 1, 1, 8, 0, 0);
        @(negedge clk);
        chk("self_issue", issue, 1);
        chk("self_stall", stall, 0);
        tick();
        @(negedge clk);
        chk("self_again_stall", stall, 1);
        tick();
        exp_cnt++;
        idle(3);

        // Same-register overlap: reissue rd=9 as the old rd=9 retires
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        idle(2);
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0);
        @(negedge clk);
        chk("ovl_issue", issue, 1);
        chk("ovl_pend_before", pending[9], 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ovl_pend_held", pending[9], 1);
        chk("ovl_count", stall_count, exp_cnt);
        idle(3);

        // HLT drain
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        @(negedge clk);
        chk("hlt_prod_issue", issue, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("hlt_issue", issue, 1);
        chk("hlt_halted_early", halted, 0);
        tick();
        drv(1, 0, 0, 1, 0, 1, 10, 0, 0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("hlt_block_issue", issue, 0);
            chk("hlt_block_stall", stall, 0);
            chk("hlt_pending", pending, (c < 4) ? 32'h0000_0020 : 32'h0);
            chk("hlt_halted", halted, c >= 5);
            tick();
        end

        // Async reset mid-flight
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", halted, 0);
        tick();
        rst_n = 1'b1;
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        drv(1, 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_stall", stall, 1);
        tick();
        drv(1, 0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 4, 1, 0);
        @(negedge clk);
        chk("mid_hlt_issue", issue, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_pending", pending, 32'h0000_001C);
        chk("mid_count", stall_count, 1);
        chk("mid_blocked", issue, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", pending, 0);
        chk("arst_halted", halted, 0);
        chk("arst_count", stall_count, 0);
        chk("arst_issue", issue, 1);
        tick();
        rst_n = 1'b1;

        // Saturation: self-dependent instruction held in decode
        drv(1, 6, 0, 1, 0, 1, 6, 0, 0);
        st = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("sat_issue", issue, (c % PERIOD) == 0);
            chk("sat_stall", stall, (c % PERIOD) != 0);
            chk("sat_count", stall_count, (st > 15) ? 15 : st);
            if ((c % PERIOD) != 0) st++;
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_final", stall_count, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_hazard_scoreboard.md
# mips_hazard_scoreboard

Parametrised issue-interlock scoreboard for the pipelined MIPS32 core. It sits between the decode stage and the execute stage. It tracks in-flight register writes and stalls any instruction whose source registers are still pending, so programs no longer need dummy filler instructions between dependent operations. It also sequences HLT so that `halted` asserts only after all older writes have retired. It counts stall cycles for performance measurement.

## Interface
Parameters:
- `NREG`, 32: architectural register count; register 0 is hard-wired zero.
- `REG_AW`, 5: register index width; must satisfy 2^REG_AW >= NREG.
- `DEPTH`, 3: cycles from issue to register-file write; legal range 1..8.
- `CW`, 16: width of the stall-cycle counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `id_valid`, input, 1: the decode stage holds an instruction that requests issue.
- `id_rs`, input, REG_AW: first source register index.
- `id_rt`, input, REG_AW: second source register index.
- `id_rs_used`, input, 1: `id_rs` is actually read by the instruction.
- `id_rt_used`, input, 1: `id_rt` is actually read by the instruction.
- `id_wr_en`, input, 1: the instruction writes a register.
- `id_rd`, input, REG_AW: destination register index.
- `id_halt`, input, 1: the instruction is HLT.
- `flush`, input, 1: taken branch; kills the decode-stage instruction this cycle.
- `issue`, output, 1: the instruction advances to execute this cycle.
- `stall`, output, 1: the instruction is held in decode this cycle.
- `pending`, output, NREG: bit i is set while register i has an in-flight write.
- `halted`, output, 1: sticky; HLT has issued and the pipeline has drained.
- `stall_count`, output, CW: saturating count of stall cycles.

## Operation
- Tracker: a shift register of DEPTH entries, each holding {valid, rd}. On every clock edge entries shift from k to k+1, and the entry in slot DEPTH-1 retires (its register write occurs that cycle).
- Slot 0 load: on an issue with `id_wr_en`=1 and `id_rd`!=0, slot 0 loads {1, id_rd}. Otherwise slot 0 loads valid=0.
- `pending[i]`: the OR over all valid slots with rd==i. `pending[0]` is always 0.
- `hazard`: (`id_rs_used` & `pending_eff[id_rs]`) | (`id_rt_used` & `pending_eff[id_rt]`). Source index 0 never creates a hazard.
- `pending_eff` is defined in Configuration.
- `halt_pend`: set when an instruction with `id_halt` issues.
- `issue` = `id_valid` & ~`hazard` & ~`flush` & ~`halt_pend`.
- `stall` = `id_valid` & `hazard` & ~`flush` & ~`halt_pend`.
- `flush` overrides `hazard`: the killed instruction neither issues nor counts as a stall.
- Once `halt_pend`=1, no further instruction issues, whatever the other inputs are.
- `halted` sets on the edge where `halt_pend`=1 and all slots are invalid, then holds until reset.
- `stall_count` increments on each cycle with `stall`=1 and saturates at 2^CW-1.

## Timing
- `issue`, `stall` and `pending` are combinational from the current inputs and state, with no input-to-state latency.
- Tracker, `halt_pend`, `halted` and `stall_count` update at the rising edge of `clk`.
- Reset values: all slots invalid, `pending`=0, `halt_pend`=0, `halted`=0, `stall_count`=0.
- Outputs during reset: `issue` and `stall` follow their equations over the reset state, so `issue`=`id_valid` & ~`flush`.
- Self-reference: an instruction whose rd equals its own rs or rt is not a hazard against itself, because the check uses pre-edge state.
- Same-register overlap: a new issue to register R in the same cycle an older write to R retires leaves `pending[R]`=1, held by the new entry.
- Reset mid-operation: all in-flight entries are discarded asynchronously and a pending halt is cancelled.
- HLT with `id_wr_en`=1: the write is tracked normally, and `halted` waits for it to retire.

## Configuration
- Macro: `SCOREBOARD_WB_BYPASS_EN`.
- Defined: the register file is write-before-read. `pending_eff` excludes the entry in slot DEPTH-1, so a consumer may issue in the same cycle its producer writes back.
- Undefined: `pending_eff` = `pending`, and the consumer waits one more cycle.
- `pending` reports all valid slots in both builds.

## Test plan
- RAW chain, DEPTH=3:
  - Stimulus: ADDI writing rd=1, then next cycle ADD reading rs=1.
  - Required response with bypass defined: `stall` for 2 cycles, `issue` in the 3rd.
  - Required response with bypass undefined: 3 stall cycles.
  - `stall_count` equals the stall cycles seen.
- Independent stream:
  - Stimulus: rd=1,2,3 back to back, then a reader of rs=4, rt=5.
  - Required response: zero stalls and `pending`=0b1110 at the peak.
- R0 handling:
  - Stimulus: write rd=0, then read rs=0.
  - Required response: `pending`=0 and no stall.
- Flush priority:
  - Stimulus: hazardous instruction with `flush`=1.
  - Required response: `issue`=0, `stall`=0, `stall_count` unchanged.
- HLT drain:
  - Stimulus: issue rd=5, then HLT the next cycle, with `id_valid` held at 1.
  - Required response: no further `issue`.
  - Required response: `halted` rises exactly when the rd=5 entry has retired, and stays high.
- Async reset mid-flight:
  - Stimulus: assert `rst_n`=0 with 3 valid slots and `halt_pend`=1.
  - Required response: `pending`, `halted` and `stall_count` drop to 0 immediately, without a clock edge.
- Saturation:
  - Stimulus: CW=4, 20 stall cycles.
  - Required response: `stall_count`=15.
